// File: rtl/inst_queue_nway_pkg.sv
// Shared definitions for the N-wide instruction queue.
// Holds the fetch bundle, the default sizes and the pointer/count widths.
package inst_queue_nway_pkg;

    localparam int IQ_DEPTH = 16;
    localparam int IQ_IN_W  = 2;
    localparam int IQ_OUT_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        isBr;
        logic        isJ;
        logic        isDs;
    } InstBundle;

    typedef logic [$clog2(IQ_DEPTH)-1:0] iq_ptr_t;
    typedef logic [$clog2(IQ_DEPTH):0]   iq_cnt_t;

    function automatic logic isCti(input InstBundle b);
        return b.isBr | b.isJ;
    endfunction

endpackage

// File: rtl/inst_queue_nway_if.sv
// Fetch-side and issue-side handshake bundle of the instruction queue.
// The master drives fetch groups and out_ready; the slave is the queue.
interface inst_queue_nway_if #(
    parameter int DEPTH = inst_queue_nway_pkg::IQ_DEPTH,
    parameter int IN_W  = inst_queue_nway_pkg::IQ_IN_W,
    parameter int OUT_W = inst_queue_nway_pkg::IQ_OUT_W
) ();
    import inst_queue_nway_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [IN_W-1:0]  in_valid;
    InstBundle        in_inst [IN_W];
    logic             pause_req;
    logic             out_ready;
    logic [OUT_W-1:0] out_valid;
    InstBundle        out_inst [OUT_W];
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_inst, out_ready,
        input  pause_req, out_valid, out_inst, count
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output pause_req, out_valid, out_inst, count
    );

endinterface

// File: rtl/inst_group_select.sv
// Picks the issuable prefix of up to OUT_W candidates so that a
// branch/jump never leaves without its delay slot; rewrites isDs.
module inst_group_select
    import inst_queue_nway_pkg::*;
#(
    parameter int OUT_W = IQ_OUT_W
) (
    input  InstBundle        cand [OUT_W],
    input  logic [OUT_W-1:0] candValid,
    output logic [2:0]       nOut,
    output logic [OUT_W-1:0] outValid,
    output InstBundle        outInst [OUT_W]
);

    logic             stop;
    logic [OUT_W:0]   nextV;

    assign nextV = {1'b0, candValid};

    always_comb begin
        stop = 1'b0;
        nOut = '0;
        for (int k = 0; k < OUT_W; k++) begin
            if (!stop) begin
                if (!candValid[k]) begin
                    stop = 1'b1;
                end else if (isCti(cand[k]) && !nextV[k+1]) begin
                    stop = 1'b1;
                end else begin
                    nOut = 3'(k + 1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < OUT_W; i++) begin
            outValid[i] = 3'(i) < nOut;
            outInst[i]  = cand[i];
        end
        outInst[0].isDs = 1'b0;
        for (int i = 1; i < OUT_W; i++) begin
            outInst[i].isDs = isCti(cand[i-1]);
        end
    end

endmodule

// File: rtl/inst_queue_nway.sv
// Circular instruction queue between fetch and decode, with holey-group
// compaction, delay-slot aware issue and an empty-queue bypass.
module inst_queue_nway
    import inst_queue_nway_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int IN_W   = IQ_IN_W,
    parameter int OUT_W  = IQ_OUT_W,
    parameter int BYPASS = 1
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    inst_queue_nway_if.slave io
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int MW = (IN_W > OUT_W) ? IN_W : OUT_W;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t FULL = cnt_t'(DEPTH);
    localparam cnt_t INW  = cnt_t'(IN_W);

    ptr_t      head;
    ptr_t      tail;
    cnt_t      count;
    InstBundle mem [DEPTH];

    InstBundle        cIn [MW];
    cnt_t             nIn;
    int               rank;
    logic             pauseReq;
    logic             bypass;
    logic             enq;
    logic             fire;
    cnt_t             nEnq;
    cnt_t             nDeq;
    ptr_t             rdIdx;

    InstBundle        cand [OUT_W];
    logic [OUT_W-1:0] candValid;
    logic [2:0]       selN;
    logic [OUT_W-1:0] selValid;
    InstBundle        selInst [OUT_W];

    // Slot j of the compacted group is the j-th valid input slot.
    always_comb begin
        rank = 0;
        for (int j = 0; j < MW; j++) cIn[j] = '0;
        for (int s = 0; s < IN_W; s++) begin
            if (io.in_valid[s]) begin
                for (int j = 0; j < MW; j++) begin
                    if (rank == j) cIn[j] = io.in_inst[s];
                end
                rank = rank + 1;
            end
        end
        nIn = cnt_t'(rank);
    end

    assign pauseReq = (FULL - count) < INW;
    assign bypass   = (BYPASS != 0) && (count == '0) && !flush;
    assign enq      = !pauseReq && !flush;

    always_comb begin
        rdIdx = head;
        for (int k = 0; k < OUT_W; k++) begin
            rdIdx = head + ptr_t'(k);
            if (bypass) begin
                cand[k]      = cIn[k];
                candValid[k] = cnt_t'(k) < nIn;
            end else begin
                cand[k]      = mem[rdIdx];
                candValid[k] = cnt_t'(k) < count;
            end
        end
    end

    inst_group_select #(.OUT_W(OUT_W)) u_sel (
        .cand      (cand),
        .candValid (candValid),
        .nOut      (selN),
        .outValid  (selValid),
        .outInst   (selInst)
    );

    assign io.out_valid = (rst && !flush) ? selValid : '0;
    assign io.out_inst  = selInst;
    assign io.pause_req = pauseReq;
    assign io.count     = count;

    assign fire = io.out_ready && (|io.out_valid);
    assign nDeq = fire ? cnt_t'(selN) : '0;
    assign nEnq = enq ? nIn : '0;

    // Bypass still writes the whole group at tail: head==tail when empty,
    // so advancing head by n_out leaves exactly the unissued remainder.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ptr_t'(nDeq);
            tail  <= tail + ptr_t'(nEnq);
            count <= count + nEnq - nDeq;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            for (int j = 0; j < IN_W; j++) begin
                if (cnt_t'(j) < nIn) mem[tail + ptr_t'(j)] <= cIn[j];
            end
        end
    end

endmodule

// File: tb/tb_inst_queue_nway.sv
// Random and directed stimulus for inst_queue_nway, checked every cycle
// against a queue-based model of the issue rules.
module tb_inst_queue_nway;
    import inst_queue_nway_pkg::*;

    localparam int DEPTH = 16;
    localparam int IN_W  = 2;
    localparam int OUT_W = 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    inst_queue_nway_if #(
        .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W)
    ) bus ();

    inst_queue_nway #(
        .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .BYPASS(1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .io    (bus)
    );

    int checks = 0;
    int errors = 0;
    int seq    = 0;

    InstBundle        mq [$];
    InstBundle        cin [$];
    InstBundle        cnd [$];
    InstBundle        e;
    int               qs;
    int               n;
    bit               expPause;
    logic [OUT_W-1:0] expV;

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic InstBundle mk(input logic br, input logic j);
        InstBundle b;
        b.pc   = 32'(seq);
        seq++;
        b.inst = $urandom;
        b.isBr = br;
        b.isJ  = j;
        b.isDs = 1'($urandom);
        return b;
    endfunction

    function automatic bit cti(input InstBundle b);
        return (b.isBr == 1'b1) || (b.isJ == 1'b1);
    endfunction

    // Model: occupancy is mq.size(); the issue group is the longest
    // prefix in which no branch/jump is the last visible candidate.
    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_count", bus.count, 0);
            chk("rst_pause", bus.pause_req, 0);
        end else begin
            qs = mq.size();
            expPause = (DEPTH - qs) < IN_W;
            cin.delete();
            for (int s = 0; s < IN_W; s++)
                if (bus.in_valid[s]) cin.push_back(bus.in_inst[s]);
            cnd.delete();
            if (!flush) begin
                if (qs > 0) begin
                    for (int k = 0; k < OUT_W && k < qs; k++)
                        cnd.push_back(mq[k]);
                end else begin
                    for (int k = 0; k < OUT_W && k < cin.size(); k++)
                        cnd.push_back(cin[k]);
                end
            end
            n = 0;
            while (n < cnd.size() &&
                   (!cti(cnd[n]) || n + 1 < cnd.size()))
                n++;
            expV = OUT_W'((1 << n) - 1);
            chk("count", bus.count, qs);
            chk("pause", bus.pause_req, expPause);
            chk("out_valid", bus.out_valid, expV);
            for (int i = 0; i < n; i++) begin
                e = cnd[i];
                e.isDs = 1'b0;
                if (i > 0) e.isDs = cti(cnd[i-1]);
                chk($sformatf("slot%0d", i), bus.out_inst[i], e);
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (!expPause) foreach (cin[i]) mq.push_back(cin[i]);
                if (bus.out_ready && n > 0)
                    repeat (n) void'(mq.pop_front());
            end
        end
    end

    task automatic cyc(input logic [IN_W-1:0] v,
                       input InstBundle a,
                       input InstBundle b,
                       input logic rdy,
                       input logic fl);
        @(posedge clk);
        #1;
        bus.in_valid   = v;
        bus.in_inst[0] = a;
        bus.in_inst[1] = b;
        bus.out_ready  = rdy;
        flush          = fl;
        @(negedge clk);
        #1;
    endtask

    InstBundle z;
    logic      rdy;
    int        r0;
    int        r1;

    initial begin
        z = '0;
        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = '1;
        bus.in_inst[0] = mk(0, 0);
        bus.in_inst[1] = mk(0, 0);
        bus.out_ready = 1'b1;
        #2;
        chk("hold_rst_valid", bus.out_valid, 0);
        chk("hold_rst_pause", bus.pause_req, 0);
        chk("hold_rst_count", bus.count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = '0;
        bus.out_ready = 1'b0;

        // fill to 16, then drain 2 per cycle
        for (int g = 0; g < 8; g++) begin
            cyc(2'b11, mk(0, 0), mk(0, 0), 0, 0);
            if (g == 7) begin
                chk("fill14_count", bus.count, 14);
                chk("fill14_pause", bus.pause_req, 0);
            end
        end
        cyc(2'b00, z, z, 0, 0);
        chk("full_count", bus.count, 16);
        chk("full_pause", bus.pause_req, 1);
        for (int d = 0; d < 8; d++) begin
            cyc(2'b00, z, z, 1, 0);
            chk("drain_count", bus.count, 16 - 2 * d);
        end

        // walk head to 15, then straddle the wrap
        for (int i = 0; i < 15; i++) cyc(2'b01, mk(0, 0), z, 0, 0);
        for (int d = 0; d < 8; d++) cyc(2'b00, z, z, 1, 0);
        cyc(2'b10, z, mk(0, 0), 0, 0);
        chk("wrap_empty", bus.count, 0);
        cyc(2'b11, mk(0, 0), mk(0, 0), 0, 0);
        chk("wrap_one", bus.count, 1);
        cyc(2'b00, z, z, 1, 0);
        chk("wrap_count", bus.count, 3);
        chk("wrap_valid", bus.out_valid, 2'b11);
        cyc(2'b00, z, z, 1, 0);
        cyc(2'b00, z, z, 1, 0);

        // branch held until its delay slot arrives
        cyc(2'b11, mk(0, 0), mk(1, 0), 1, 0);
        chk("ds_first", bus.out_valid, 2'b01);
        cyc(2'b00, z, z, 1, 0);
        chk("ds_hold_count", bus.count, 1);
        chk("ds_hold_valid", bus.out_valid, 2'b00);
        cyc(2'b11, mk(0, 0), mk(0, 0), 1, 0);
        chk("ds_hold2", bus.out_valid, 2'b00);
        cyc(2'b00, z, z, 1, 0);
        chk("ds_pair", bus.out_valid, 2'b11);
        chk("ds_br", bus.out_inst[0].isBr, 1);
        chk("ds_bit", bus.out_inst[1].isDs, 1);
        cyc(2'b00, z, z, 1, 0);
        chk("ds_tail", bus.out_valid, 2'b01);
        cyc(2'b00, z, z, 1, 0);

        // bypass splits off a trailing jump
        cyc(2'b11, mk(0, 0), mk(0, 1), 1, 0);
        chk("byp_valid", bus.out_valid, 2'b01);
        chk("byp_ds0", bus.out_inst[0].isDs, 0);
        cyc(2'b11, mk(0, 0), mk(0, 0), 1, 0);
        chk("byp_count", bus.count, 1);
        cyc(2'b00, z, z, 1, 0);
        chk("byp_pair", bus.out_valid, 2'b11);
        cyc(2'b00, z, z, 1, 0);
        cyc(2'b00, z, z, 1, 0);

        // flush beats concurrent enqueue/dequeue
        for (int i = 0; i < 3; i++) cyc(2'b11, mk(0, 0), mk(0, 0), 0, 0);
        cyc(2'b11, mk(0, 0), mk(0, 0), 1, 1);
        chk("fl_count", bus.count, 6);
        chk("fl_valid", bus.out_valid, 0);
        cyc(2'b00, z, z, 1, 0);
        chk("fl_after", bus.count, 0);
        chk("fl_after_v", bus.out_valid, 0);

        // 2 in and 2 out keeps occupancy
        cyc(2'b11, mk(0, 0), mk(0, 0), 0, 0);
        cyc(2'b11, mk(0, 0), mk(0, 0), 0, 0);
        cyc(2'b01, mk(0, 0), z, 0, 0);
        cyc(2'b11, mk(0, 0), mk(0, 0), 1, 0);
        chk("cc_count", bus.count, 5);
        cyc(2'b00, z, z, 0, 0);
        chk("cc_after", bus.count, 5);
        for (int d = 0; d < 3; d++) cyc(2'b00, z, z, 1, 0);

        // asynchronous reset mid-cycle
        for (int i = 0; i < 4; i++) cyc(2'b11, mk(0, 0), mk(0, 0), 0, 0);
        cyc(2'b01, mk(0, 0), z, 0, 0);
        cyc(2'b00, z, z, 1, 0);
        chk("ar_before", bus.count, 9);
        rst = 1'b0;
        #1;
        chk("ar_count", bus.count, 0);
        chk("ar_valid", bus.out_valid, 0);
        chk("ar_pause", bus.pause_req, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 2'b11;
        bus.in_inst[0] = mk(0, 0);
        bus.in_inst[1] = mk(0, 0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        cyc(2'b00, z, z, 0, 0);
        chk("ar_first", bus.count, 2);

        // random traffic with alternating backpressure phases
        for (int c = 0; c < 3000; c++) begin
            r0 = $urandom_range(0, 9);
            r1 = $urandom_range(0, 9);
            if (((c / 200) % 2) == 1) rdy = ($urandom_range(0, 3) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            cyc(2'($urandom),
                mk(r0 < 2, r0 == 2),
                mk(r1 < 2, r1 == 2),
                rdy,
                $urandom_range(0, 40) == 0);
        end
        for (int d = 0; d < 12; d++) cyc(2'b00, z, z, 1, 0);
        cyc(2'b11, mk(0, 0), mk(0, 0), 1, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
